// File: rtl/alu_serial_pkg.sv
// Shared types and constants for the bit-serial ALU: FSM states, control codes,
// slice operations and the control decoder.
package alu_serial_pkg;

    localparam int WIDTH = 32;
    localparam int IDX_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_ADD  = 2'd2,
        OP_LESS = 2'd3
    } slice_op_t;

    typedef struct packed {
        logic      a_inv;
        logic      b_inv;
        slice_op_t op;
        logic      cin0;   // carry into bit 0
        logic      arith;  // add/sub/slt: carry and overflow are meaningful
        logic      slt;
    } slice_ctrl_t;

    // Unknown control codes fall back to AND.
    function automatic slice_ctrl_t decode_ctrl(input logic [3:0] ctrl);
        slice_ctrl_t d;
        d    = '0;
        d.op = OP_AND;
        case (ctrl)
            CTRL_OR:  d.op = OP_OR;
            CTRL_ADD: begin d.op = OP_ADD; d.arith = 1'b1; end
            CTRL_SUB: begin d.op = OP_ADD; d.arith = 1'b1; d.b_inv = 1'b1; d.cin0 = 1'b1; end
            CTRL_SLT: begin d.op = OP_ADD; d.arith = 1'b1; d.b_inv = 1'b1; d.cin0 = 1'b1; d.slt = 1'b1; end
            CTRL_NOR: begin d.a_inv = 1'b1; d.b_inv = 1'b1; end
            default:  d.op = OP_AND;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_serial_if.sv
// Request/response bundle of the bit-serial ALU.
interface alu_serial_if;
    logic        start_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [3:0]  ctrl_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        cout_o;
    logic        overflow_o;
    logic        busy_o;
    logic        done_o;

    modport master (
        output start_i, src1_i, src2_i, ctrl_i,
        input  result_o, zero_o, cout_o, overflow_o, busy_o, done_o
    );

    modport slave (
        input  start_i, src1_i, src2_i, ctrl_i,
        output result_o, zero_o, cout_o, overflow_o, busy_o, done_o
    );
endinterface

// File: rtl/alu_serial_slice.sv
// One-bit ALU slice: optional operand inversion, then AND / OR / full-add / less.
module alu_serial_slice
    import alu_serial_pkg::*;
(
    input  logic      a,
    input  logic      b,
    input  logic      less,
    input  logic      a_inv,
    input  logic      b_inv,
    input  logic      cin,
    input  slice_op_t op,
    output logic      result,
    output logic      cout
);
    logic a_eff;
    logic b_eff;

    assign a_eff = a ^ a_inv;
    assign b_eff = b ^ b_inv;
    assign cout  = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);

    always_comb begin
        result = 1'b0;
        case (op)
            OP_AND:  result = a_eff & b_eff;
            OP_OR:   result = a_eff | b_eff;
            OP_ADD:  result = a_eff ^ b_eff ^ cin;
            OP_LESS: result = less;
            default: result = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_serial.sv
// Bit-serial 32-bit ALU: one bit per cycle, LSB first, result published in FIN.
// Define ALU_SERIAL_OVF_EN to register and drive overflow_o; otherwise it is tied low.
module alu_serial
    import alu_serial_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    alu_serial_if.slave  bus
);
    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, b_reg, shadow_reg, result_reg;
    slice_ctrl_t       op_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              carry_reg, c31_reg;
    logic              zero_reg, cout_reg, done_reg;
    logic              slice_cin, slice_result, slice_cout;
    logic              ovf_int;
    logic [WIDTH-1:0]  final_result;

    // Carry register is cleared on accept, so bit 0 takes the op's initial carry.
    assign slice_cin = (idx_reg == '0) ? op_reg.cin0 : carry_reg;

    alu_serial_slice u_slice (
        .a      (a_reg[idx_reg]),
        .b      (b_reg[idx_reg]),
        .less   (1'b0),
        .a_inv  (op_reg.a_inv),
        .b_inv  (op_reg.b_inv),
        .cin    (slice_cin),
        .op     (op_reg.op),
        .result (slice_result),
        .cout   (slice_cout)
    );

    // In FIN carry_reg holds c32 and c31_reg the carry into bit 31.
    assign ovf_int      = c31_reg ^ carry_reg;
    assign final_result = op_reg.slt ? {{(WIDTH-1){1'b0}}, shadow_reg[WIDTH-1] ^ ovf_int}
                                     : shadow_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.start_i) state_next = ST_RUN;
            ST_RUN:  if (idx_reg == IDX_W'(WIDTH-1)) state_next = ST_FIN;
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef ALU_SERIAL_OVF_EN
    logic ovf_reg;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                  ovf_reg <= 1'b0;
        else if (state_reg == ST_FIN) ovf_reg <= op_reg.arith & ovf_int;
    end
    assign bus.overflow_o = ovf_reg;
`else
    assign bus.overflow_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            idx_reg    <= '0;
            carry_reg  <= 1'b0;
            c31_reg    <= 1'b0;
            shadow_reg <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b1;
            cout_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        a_reg     <= bus.src1_i;
                        b_reg     <= bus.src2_i;
                        op_reg    <= decode_ctrl(bus.ctrl_i);
                        idx_reg   <= '0;
                        carry_reg <= 1'b0;
                        c31_reg   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    shadow_reg[idx_reg] <= slice_result;
                    carry_reg           <= slice_cout;
                    if (idx_reg == IDX_W'(WIDTH-1)) c31_reg <= slice_cin;
                    idx_reg <= idx_reg + 1'b1;
                end
                ST_FIN: begin
                    result_reg <= final_result;
                    zero_reg   <= (final_result == '0);
                    cout_reg   <= op_reg.arith & carry_reg;
                    done_reg   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.result_o = result_reg;
    assign bus.zero_o   = zero_reg;
    assign bus.cout_o   = cout_reg;
    assign bus.busy_o   = (state_reg != ST_IDLE);
    assign bus.done_o   = done_reg;
endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial: driver pushes reference results, monitor pops on done_o.
module tb_alu_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_serial_if bus();

    alu_serial dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        else passed++;
    endtask

    // Reference model from the operation definitions using wide integer arithmetic.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl);
        exp_t        e;
        logic [32:0] s;
        logic        ovf;
        e.cout = 1'b0; e.ovf = 1'b0; e.acc = 0;
        case (ctrl)
            4'b0001: e.result = a | b;
            4'b1100: e.result = ~(a | b);
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                e.result = s[31:0]; e.cout = s[32];
                e.ovf = (a[31] == b[31]) && (s[31] != a[31]);
            end
            4'b0110, 4'b0111: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.cout = s[32];
                ovf = (a[31] != b[31]) && (s[31] != a[31]);
                e.ovf = ovf;
                if (ctrl == 4'b0111) e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                else                 e.result = s[31:0];
            end
            default: e.result = a & b;
        endcase
`ifndef ALU_SERIAL_OVF_EN
        e.ovf = 1'b0;
`endif
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    // Monitor: compare on every done pulse, and check the outputs hold otherwise.
    logic [31:0] held_result = 32'd0;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            held_result = 32'd0;
        end else if (bus.done_o === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done_o=1 expected no pending operation (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", bus.result_o, e.result);
                chk("zero", {31'd0, bus.zero_o}, {31'd0, e.zero});
                chk("cout", {31'd0, bus.cout_o}, {31'd0, e.cout});
                chk("overflow", {31'd0, bus.overflow_o}, {31'd0, e.ovf});
                chk("latency", cyc - e.acc, 33);
                $display("op done: result=0x%08h zero=%0b cout=%0b ovf=%0b at cycle %0d",
                         bus.result_o, bus.zero_o, bus.cout_o, bus.overflow_o, cyc);
            end
            held_result = bus.result_o;
        end else begin
            chk("result_hold", bus.result_o, held_result);
        end
    end

    task automatic wait_idle();
        int w = 0;
        while (bus.busy_o !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            total++;
            $display("FAIL idle_timeout: got busy_o=%0b expected 0 within 200 cycles", bus.busy_o);
        end
    endtask

    // Called at a negedge; returns at a negedge after start has been accepted.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl, input bit push);
        exp_t e;
        wait_idle();
        bus.start_i = 1'b1; bus.src1_i = a; bus.src2_i = b; bus.ctrl_i = ctrl;
        @(posedge clk); #1;
        e = model(a, b, ctrl);
        e.acc = cyc;
        if (push) sb.push_back(e);
        $display("issue: a=0x%08h b=0x%08h ctrl=%04b at cycle %0d", a, b, ctrl, cyc);
        bus.start_i = 1'b0;
        bus.src1_i  = $urandom; bus.src2_i = $urandom; bus.ctrl_i = 4'($urandom);
        @(negedge clk);
        chk("busy_after_start", {31'd0, bus.busy_o}, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_result"}, bus.result_o, 32'd0);
        chk({tag, "_zero"}, {31'd0, bus.zero_o}, 32'd1);
        chk({tag, "_cout"}, {31'd0, bus.cout_o}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, bus.overflow_o}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.done_o}, 32'd0);
    endtask

    logic [3:0] codes [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

    initial begin
        bus.start_i = 1'b0; bus.src1_i = '0; bus.src2_i = '0; bus.ctrl_i = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed corner cases
        issue(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 1'b1);
        issue(32'h0000_0005, 32'h0000_0005, 4'b0110, 1'b1);
        issue(32'h8000_0000, 32'h0000_0001, 4'b0111, 1'b1);
        issue(32'h0000_0001, 32'hFFFF_FFFF, 4'b0111, 1'b1);
        issue(32'h7FFF_FFFF, 32'h8000_0000, 4'b0111, 1'b1);
        issue(32'h0F0F_0F0F, 32'h00FF_00FF, 4'b1100, 1'b1);
        issue(32'h0F0F_0F0F, 32'h00FF_00FF, 4'b0001, 1'b1);
        issue(32'h0F0F_0F0F, 32'h00FF_00FF, 4'b1111, 1'b1);
        issue(32'h8000_0000, 32'h8000_0000, 4'b0010, 1'b1);

        // Reset in the middle of RUN: operation discarded, no done pulse
        issue(32'h1234_5678, 32'h0000_0001, 4'b0010, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrun_reset");
        issue(32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 1'b1);

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            logic [3:0] c;
            c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 5)];
            issue($urandom, $urandom, c, 1'b1);
        end

        // start held high with operands changing every cycle
        wait_idle();
        begin
            int accepts = 0;
            int last_acc = -1;
            int guard = 0;
            bus.start_i = 1'b1;
            while (accepts < 8 && guard < 2000) begin
                logic was_idle;
                exp_t e;
                bus.src1_i = $urandom; bus.src2_i = $urandom;
                bus.ctrl_i = codes[$urandom_range(0, 5)];
                was_idle = (bus.busy_o === 1'b0);
                @(posedge clk); #1;
                if (was_idle) begin
                    e = model(bus.src1_i, bus.src2_i, bus.ctrl_i);
                    e.acc = cyc;
                    sb.push_back(e);
                    $display("stream accept: a=0x%08h b=0x%08h ctrl=%04b at cycle %0d",
                             bus.src1_i, bus.src2_i, bus.ctrl_i, cyc);
                    if (last_acc >= 0) chk("throughput", cyc - last_acc, 34);
                    last_acc = cyc;
                    accepts++;
                end
                @(negedge clk);
                guard++;
            end
            if (accepts < 8) begin
                total++;
                $display("FAIL stream_timeout: got %0d accepts expected 8", accepts);
            end
            bus.start_i = 1'b0;
        end

        begin
            int w = 0;
            while (sb.size() != 0 && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (sb.size() != 0) begin
                total++;
                $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            end
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_serial.md
ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 SHALL have port clk_i, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_i, input, 1; asynchronous, active-high reset.
REQ-003 SHALL have port start_i, input, 1; request a new operation; sampled only in IDLE.
REQ-004 SHALL have port src1_i, input, 32; operand A, latched on the accepted start.
REQ-005 SHALL have port src2_i, input, 32; operand B, latched on the accepted start.
REQ-006 SHALL have port ctrl_i, input, 4; ALU control, latched on the accepted start.
REQ-007 SHALL have port result_o, output, 32; final result, held until the next accepted start.
REQ-008 SHALL have port zero_o, output, 1; result_o == 0.
REQ-009 SHALL have port cout_o, output, 1; carry out of bit 31.
REQ-010 SHALL have port overflow_o, output, 1; signed overflow of add/sub.
REQ-011 SHALL have port busy_o, output, 1; high from the cycle after an accepted start until done.
REQ-012 SHALL have port done_o, output, 1; one-cycle pulse when the outputs become valid.

Function
REQ-013 SHALL decode ctrl_i as follows; any other code SHALL behave as AND.
- 0000 AND
- 0001 OR
- 0010 ADD
- 0110 SUB
- 0111 SLT
- 1100 NOR
REQ-014 SHALL derive per-op slice controls:
- A_inv: NOR only.
- B_inv: SUB, SLT, NOR.
- Slice op: AND for AND/NOR; OR for OR; ADD for ADD/SUB/SLT.
- Initial carry: 1 for SUB/SLT, else 0.
REQ-015 SHALL implement an FSM with states IDLE, RUN and FIN.
REQ-016 IDLE -> RUN when start_i=1; this edge latches the operands and control and clears bit index and carry.
REQ-017 RUN SHALL process one bit per cycle, LSB first:
- Bit index 0..31.
- Carry register updated from the slice carry-out each cycle.
- Result bit written at the current index.
REQ-018 RUN -> FIN after bit index 31 is processed; FIN -> IDLE unconditionally.
REQ-019 In FIN the block SHALL:
- Finalize cout_o and overflow_o.
- Set overflow_o = c31 ^ c32 for ADD/SUB/SLT, else 0.
- For SLT, replace result with {31'b0, sum[31] ^ ovf}, ovf computed internally regardless of REQ-025.
- Compute zero_o from the final result.
- Pulse done_o.
REQ-020 Latency: done_o SHALL be asserted exactly 33 cycles after the clock edge that accepted start_i.
REQ-021 start_i SHALL be ignored while busy_o=1 or in FIN; start_i in the IDLE cycle after FIN SHALL be accepted (back-to-back throughput 34 cycles).
REQ-022 result_o, zero_o, cout_o and overflow_o SHALL change only in FIN or on reset; intermediate bits SHALL be kept in a shadow register.

Reset
REQ-023 On rst_i=1, asynchronously and at any state including mid-RUN, the block SHALL enter IDLE with result_o=0, zero_o=1, cout_o=0, overflow_o=0, busy_o=0, done_o=0, and clear all internal registers.
REQ-024 An operation interrupted by reset SHALL be discarded; no done_o pulse.

Configuration
REQ-025 With macro ALU_SERIAL_OVF_EN defined, overflow_o SHALL behave per REQ-019; without it, overflow_o SHALL be tied 0 and its output register omitted, while SLT results stay correct.

Structure
REQ-026 A shared package alu_serial_pkg SHALL hold:
- FSM state typedef.
- ctrl code constants (per REQ-013).
- Slice op constants.
- Width constant 32.
REQ-027 The 1-bit combinational slice SHALL be a sub-module alu_serial_slice (inputs a, b, less, a_inv, b_inv, cin, op; outputs result, cout), instantiated once.

Verification
REQ-028 ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1 (macro on), cout 0, zero 0, done at cycle 33.
REQ-029 SUB 0x00000005 - 0x00000005 -> result 0, zero 1, cout 1, overflow 0.
REQ-030 SLT 0x80000000 vs 0x00000001 -> result 1; SLT 0x00000001 vs 0xFFFFFFFF -> result 0.
REQ-031 NOR 0x0F0F0F0F, 0x00FF00FF -> 0xF000F000; OR same operands -> 0x0FFF0FFF; ctrl 1111 -> AND result 0x000F000F.
REQ-032 rst_i pulsed at cycle 10 of RUN -> outputs at reset values, no done_o; new start accepted next cycle completes correctly.
REQ-033 start_i held high continuously with changing operands -> only IDLE-sampled values used, done_o every 34 cycles.
